// File: rtl/text_grid_engine.sv
// text_grid_engine: COLS x ROWS character-cell display with a valid/ready
// write port, auto-incrementing write pointer, clear-screen sequencer,
// per-cell colour/inverse attributes, blinking cursor and a 2-stage render
// pipeline that keeps rgb aligned with the delayed syncs.
module text_grid_engine #(
  parameter int         COLS         = 32,
  parameter int         ROWS         = 30,
  parameter int         HBITS        = 9,
  parameter int         VBITS        = 9,
  parameter int         BLINK_FRAMES = 32,
  parameter logic [7:0] FILL         = 8'h0A,
  localparam int        CB           = $clog2(COLS),
  localparam int        RB           = $clog2(ROWS),
  localparam int        ABITS        = RB + CB
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [HBITS-1:0] hpos,
  input  logic [VBITS-1:0] vpos,
  input  logic             display_on,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             wr_valid,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  input  logic             ptr_load,
  input  logic [ABITS-1:0] ptr_addr,
  output logic [ABITS-1:0] wr_ptr,
  input  logic             clear_req,
  output logic             clear_busy,
  output logic             hsync,
  output logic             vsync,
  output logic [2:0]       rgb
);

  localparam int               CELLS = COLS * ROWS;
  localparam logic [ABITS-1:0] LAST  = ABITS'(CELLS - 1);
  localparam int               FBITS = $clog2(BLINK_FRAMES + 1);
  localparam logic [FBITS-1:0] FLAST = FBITS'(BLINK_FRAMES - 1);
  localparam int               CFW   = HBITS - 3;
  localparam int               RFW   = VBITS - 3;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  // 5x8 digit glyphs, row 0 first, leftmost pixel in the MSB; 10-15 blank
  function automatic logic [4:0] glyph_rom(input logic [3:0] g, input logic [2:0] y);
    logic [7:0][4:0] r;
    case (g)
      4'd0:    r = 40'b01110_10001_10011_10101_11001_10001_01110_00000;
      4'd1:    r = 40'b00100_01100_00100_00100_00100_00100_01110_00000;
      4'd2:    r = 40'b01110_10001_00001_00010_00100_01000_11111_00000;
      4'd3:    r = 40'b11111_00010_00100_00010_00001_10001_01110_00000;
      4'd4:    r = 40'b00010_00110_01010_10010_11111_00010_00010_00000;
      4'd5:    r = 40'b11111_10000_11110_00001_00001_10001_01110_00000;
      4'd6:    r = 40'b00110_01000_10000_11110_10001_10001_01110_00000;
      4'd7:    r = 40'b11111_00001_00010_00100_01000_01000_01000_00000;
      4'd8:    r = 40'b01110_10001_10001_01110_10001_10001_01110_00000;
      4'd9:    r = 40'b01110_10001_10001_01111_00001_00010_01100_00000;
      default: r = '0;
    endcase
    return r[3'd7 - y];
  endfunction

  state_t           state_q;
  logic [ABITS-1:0] clr_cnt_q, wr_ptr_q;
  logic             wr_ready_q, clear_busy_q;
  logic [FBITS-1:0] frame_cnt_q;
  logic             blink_q;

  logic [7:0]       ram [CELLS];

  logic             load_ok, wr_acc, ram_we;
  logic [ABITS-1:0] wr_tgt, ptr_d, ram_waddr;
  logic [7:0]       ram_wdata;

  // Write-port arbitration: the clear sequencer owns the port while clearing
  always_comb begin
    load_ok = ptr_load && (ptr_addr <= LAST);
    wr_acc  = wr_valid && wr_ready_q;
    wr_tgt  = load_ok ? ptr_addr : wr_ptr_q;
    ptr_d   = (wr_tgt == LAST) ? '0 : wr_tgt + 1'b1;
    if (state_q == S_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt_q;
      ram_wdata = FILL;
    end else begin
      ram_we    = wr_acc;
      ram_waddr = wr_tgt;
      ram_wdata = wr_data;
    end
  end

  // Character RAM write port (no reset: contents are rebuilt by the clear)
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  // Control FSM: clear sequencer, write pointer and handshake flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_CLEAR;
      clr_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      wr_ready_q   <= 1'b0;
      clear_busy_q <= 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (clear_req) begin
            clr_cnt_q <= '0;
          end else if (clr_cnt_q == LAST) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            wr_ready_q   <= 1'b1;
            clear_busy_q <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (load_ok) wr_ptr_q <= ptr_addr;
          end
        end
        default: begin
          if (wr_acc)       wr_ptr_q <= ptr_d;
          else if (load_ok) wr_ptr_q <= ptr_addr;
          if (clear_req) begin
            state_q      <= S_CLEAR;
            clr_cnt_q    <= '0;
            wr_ready_q   <= 1'b0;
            clear_busy_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Frame counter and cursor blink phase, ticked at the top-left pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (hpos == '0 && vpos == '0) begin
      if (frame_cnt_q == FLAST) begin
        frame_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  // ---- stage 0: cell address decode and RAM read ----
  logic [CFW-1:0]   col_full;
  logic [RFW-1:0]   row_full;
  logic [ABITS-1:0] rd_addr;
  logic             in_grid;

  always_comb begin
    col_full = hpos[HBITS-1:3];
    row_full = vpos[VBITS-1:3];
    in_grid  = (col_full < CFW'(COLS)) && (row_full < RFW'(ROWS));
    rd_addr  = {row_full[RB-1:0], col_full[CB-1:0]};
  end

  logic [7:0] cell_p0_q;
  logic [2:0] xofs_p0_q, yofs_p0_q;
  logic       ingrid_p0_q, cursor_p0_q, de_p0_q, hs_p0_q, vs_p0_q;

  // Stage-0 registers: RAM read data plus the pixel context that travels with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cell_p0_q   <= '0;
      xofs_p0_q   <= '0;
      yofs_p0_q   <= '0;
      ingrid_p0_q <= 1'b0;
      cursor_p0_q <= 1'b0;
      de_p0_q     <= 1'b0;
      hs_p0_q     <= 1'b0;
      vs_p0_q     <= 1'b0;
    end else begin
      cell_p0_q   <= ram[rd_addr];
      xofs_p0_q   <= hpos[2:0];
      yofs_p0_q   <= vpos[2:0];
      ingrid_p0_q <= in_grid;
      cursor_p0_q <= in_grid && (rd_addr == wr_ptr_q);
      de_p0_q     <= display_on;
      hs_p0_q     <= hsync_in;
      vs_p0_q     <= vsync_in;
    end
  end

  // ---- stage 1: glyph lookup, attribute mixing, output registers ----
  logic [7:0] line_p1;
  logic       pix_p1;

  always_comb begin
    line_p1 = {glyph_rom(cell_p0_q[3:0], yofs_p0_q), 3'b000};
    pix_p1  = line_p1[3'd7 - xofs_p0_q] ^ cell_p0_q[7] ^ (cursor_p0_q & blink_q);
  end

  logic [2:0] rgb_q;
  logic       hs_q, vs_q;

  // Output registers: colour gated by visibility and grid bounds
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_q <= '0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      rgb_q <= (de_p0_q && ingrid_p0_q && pix_p1) ? cell_p0_q[6:4] : 3'b000;
      hs_q  <= hs_p0_q;
      vs_q  <= vs_p0_q;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign clear_busy = clear_busy_q;
  assign wr_ptr     = wr_ptr_q;
  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign rgb        = rgb_q;

endmodule

// File: tb/tb_text_grid_engine.sv
// Self-checking bench for text_grid_engine (BLINK_FRAMES=2 so blinking is
// reachable quickly). Render expectations go through a scoreboard queue.
module tb_text_grid_engine;

  localparam int COLS  = 32;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam int BF    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] hpos = 9'h1FF, vpos = 9'h1FF;
  logic       display_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic       ptr_load = 1'b0;
  logic [9:0] ptr_addr = 10'd0;
  logic [9:0] wr_ptr;
  logic       clear_req = 1'b0;
  logic       clear_busy, hsync, vsync;
  logic [2:0] rgb;

  text_grid_engine #(.BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .ptr_load(ptr_load), .ptr_addr(ptr_addr), .wr_ptr(wr_ptr),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference glyphs, one 5-bit row per entry, leftmost pixel in bit 4
  logic [4:0] glyph_m [10][8] = '{
    '{5'b01110,5'b10001,5'b10011,5'b10101,5'b11001,5'b10001,5'b01110,5'b00000},
    '{5'b00100,5'b01100,5'b00100,5'b00100,5'b00100,5'b00100,5'b01110,5'b00000},
    '{5'b01110,5'b10001,5'b00001,5'b00010,5'b00100,5'b01000,5'b11111,5'b00000},
    '{5'b11111,5'b00010,5'b00100,5'b00010,5'b00001,5'b10001,5'b01110,5'b00000},
    '{5'b00010,5'b00110,5'b01010,5'b10010,5'b11111,5'b00010,5'b00010,5'b00000},
    '{5'b11111,5'b10000,5'b11110,5'b00001,5'b00001,5'b10001,5'b01110,5'b00000},
    '{5'b00110,5'b01000,5'b10000,5'b11110,5'b10001,5'b10001,5'b01110,5'b00000},
    '{5'b11111,5'b00001,5'b00010,5'b00100,5'b01000,5'b01000,5'b01000,5'b00000},
    '{5'b01110,5'b10001,5'b10001,5'b01110,5'b10001,5'b10001,5'b01110,5'b00000},
    '{5'b01110,5'b10001,5'b10001,5'b01111,5'b00001,5'b00010,5'b01100,5'b00000}
  };

  // Reference state
  logic [7:0] ram_m [CELLS];
  int         ptr_m   = 0;
  int         fc_m    = 0;
  bit         blink_m = 1'b0;

  typedef struct {
    int         due;
    int         h;
    int         v;
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: outputs appear two clocks after the pixel is driven
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (rgb !== e.rgb || hsync !== e.hs || vsync !== e.vs) begin
        n_tests++;
        n_fail++;
        $display("FAIL render(h=%0d,v=%0d): got rgb=%b hs=%b vs=%b, expected rgb=%b hs=%b vs=%b",
                 e.h, e.v, rgb, hsync, vsync, e.rgb, e.hs, e.vs);
      end else begin
        n_tests++;
      end
    end
  end

  function automatic logic [2:0] model_rgb(input int h, input int v, input bit de);
    int col, row, idx, x, y;
    logic [7:0] c;
    logic gb, pix;
    col = h / 8; row = v / 8; x = h % 8; y = v % 8;
    if (!de || col >= COLS || row >= ROWS) return 3'b000;
    idx = row * COLS + col;
    c   = ram_m[idx];
    gb  = 1'b0;
    if (c[3:0] < 4'd10 && x < 5) gb = glyph_m[c[3:0]][y][4 - x];
    pix = gb ^ c[7] ^ ((idx == ptr_m) && blink_m);
    return pix ? c[6:4] : 3'b000;
  endfunction

  // Drive one pixel for one clock and queue its expected outputs
  task automatic px(input int h, input int v, input bit de, input bit hs, input bit vs,
                    input bit use_tbl, input logic [2:0] tbl_rgb);
    exp_t e;
    hpos = h[8:0]; vpos = v[8:0]; display_on = de; hsync_in = hs; vsync_in = vs;
    if (h == 0 && v == 0) begin
      if (fc_m == BF - 1) begin fc_m = 0; blink_m = !blink_m; end
      else fc_m++;
    end
    e.due = cyc + 2; e.h = h; e.v = v;
    e.rgb = use_tbl ? tbl_rgb : model_rgb(h, v, de);
    e.hs = hs; e.vs = vs;
    sb.push_back(e);
    @(negedge clk);
    hpos = 9'h1FF; vpos = 9'h1FF; display_on = 1'b0;
  endtask

  // One clock of write-port activity, mirrored into the reference model
  task automatic wr(input bit v, input logic [7:0] d, input bit ld, input int a, input bit clr);
    bit acc, ok;
    int tgt;
    wr_valid = v; wr_data = d; ptr_load = ld; ptr_addr = a[9:0]; clear_req = clr;
    acc = v && (wr_ready === 1'b1);
    ok  = ld && (a < CELLS);
    if (acc) begin
      tgt = ok ? a : ptr_m;
      ram_m[tgt] = d;
      ptr_m = (tgt == CELLS - 1) ? 0 : tgt + 1;
    end else if (ok) begin
      ptr_m = a;
    end
    @(negedge clk);
    wr_valid = 1'b0; ptr_load = 1'b0; clear_req = 1'b0;
  endtask

  // Wait for the clear to finish; start is the last edge before the first fill write
  task automatic wait_clear(input int start, input string name);
    int t = 0;
    while (clear_busy === 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: clear_busy still %b after %0d cycles, expected 0", name, clear_busy, t);
    end
    check({name, "_cycles"}, cyc - start, CELLS);
    check({name, "_ready"}, wr_ready, 1);
    check({name, "_ptr"}, wr_ptr, 0);
    for (int i = 0; i < CELLS; i++) ram_m[i] = 8'h0A;
    ptr_m = 0;
  endtask

  task automatic scan_all();
    for (int i = 0; i < CELLS; i++) px((i % COLS) * 8 + 1, (i / COLS) * 8 + 1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  typedef struct {
    int         h;
    int         v;
    bit         de;
    bit         hs;
    bit         vs;
    logic [2:0] rgb;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int   req;

    // Hand-derived pixels for cell0=0x24, cell959=0x13, cell5=0x91 and off-grid
    tbl = '{
      '{  3,   0, 1'b1, 1'b1, 1'b0, 3'b010},
      '{  1,   0, 1'b1, 1'b0, 1'b1, 3'b000},
      '{  4,   4, 1'b1, 1'b1, 1'b1, 3'b010},
      '{  5,   4, 1'b1, 1'b0, 1'b0, 3'b000},
      '{  4,   4, 1'b0, 1'b1, 1'b0, 3'b000},
      '{248, 232, 1'b1, 1'b0, 1'b1, 3'b001},
      '{253, 232, 1'b1, 1'b1, 1'b1, 3'b000},
      '{251, 233, 1'b1, 1'b0, 1'b0, 3'b001},
      '{250, 233, 1'b1, 1'b1, 1'b0, 3'b000},
      '{ 40,   1, 1'b1, 1'b0, 1'b1, 3'b001},
      '{ 41,   1, 1'b1, 1'b1, 1'b1, 3'b000},
      '{ 45,   1, 1'b1, 1'b0, 1'b0, 3'b001},
      '{ 42,   7, 1'b1, 1'b1, 1'b0, 3'b001},
      '{258,   1, 1'b1, 1'b0, 1'b1, 3'b000},
      '{ 40, 241, 1'b1, 1'b1, 1'b1, 3'b000},
      '{258, 241, 1'b1, 1'b0, 1'b0, 3'b000}
    };

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_clear_busy", clear_busy, 1);
    check("rst_wr_ptr", wr_ptr, 0);
    check("rst_rgb", rgb, 0);
    check("rst_hsync", hsync, 0);
    check("rst_vsync", vsync, 0);

    // Power-up clear
    reset = 1'b1;
    req = cyc;
    @(negedge clk);
    check("boot_busy_early", clear_busy, 1);
    wait_clear(req, "boot_clear");

    // Fill every cell with an all-lit pattern, then scan it
    for (int i = 0; i < CELLS; i++) wr(1'b1, 8'hFF, 1'b0, 0, 1'b0);
    check("fill_wrap_ptr", wr_ptr, 0);
    scan_all();

    // Clear requested in the middle of a write stream
    wr(1'b0, 8'h00, 1'b1, 500, 1'b0);
    wr(1'b1, 8'h11, 1'b0, 0, 1'b0);
    wr(1'b1, 8'h11, 1'b0, 0, 1'b0);
    req = cyc + 1;
    wr(1'b1, 8'h11, 1'b0, 0, 1'b1);
    check("clrreq_ready_low", wr_ready, 0);
    check("clrreq_busy_high", clear_busy, 1);
    check("clrreq_ptr", wr_ptr, 503);
    wr(1'b1, 8'h55, 1'b0, 0, 1'b0);
    check("clrreq_blocked_ptr", wr_ptr, 503);
    px(177, 121, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    px(169, 121, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000);
    px(185, 121, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
    wait_clear(req, "req_clear");
    scan_all();

    // Digit "7" in green at cell 0
    wr(1'b1, 8'h27, 1'b1, 0, 1'b0);
    check("seven_ptr", wr_ptr, 1);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        px(x, y, 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 3'b000);

    // Pointer wrap across the last cell
    wr(1'b0, 8'h00, 1'b1, 959, 1'b0);
    wr(1'b1, 8'h13, 1'b0, 0, 1'b0);
    wr(1'b1, 8'h24, 1'b0, 0, 1'b0);
    check("wrap_ptr", wr_ptr, 1);

    // Load and write in the same cycle; out-of-range loads
    wr(1'b1, 8'h91, 1'b1, 5, 1'b0);
    check("ldwr_ptr", wr_ptr, 6);
    wr(1'b0, 8'h00, 1'b1, 1000, 1'b0);
    check("bad_load_ptr", wr_ptr, 6);
    wr(1'b1, 8'h3C, 1'b1, 1000, 1'b0);
    check("bad_load_wr_ptr", wr_ptr, 7);

    // Table-driven pixel vectors
    foreach (tbl[i]) px(tbl[i].h, tbl[i].v, tbl[i].de, tbl[i].hs, tbl[i].vs, 1'b1, tbl[i].rgb);

    // Cursor blink over several frames
    wr(1'b1, 8'h23, 1'b1, 40, 1'b0);
    wr(1'b0, 8'h00, 1'b1, 40, 1'b0);
    check("cursor_ptr", wr_ptr, 40);
    for (int f = 0; f < 6; f++) begin
      px(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
      for (int x = 0; x < 8; x++) px(64 + x, 8, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000);
    end

    // Hand-checked blink phase after 6 ticks with BLINK_FRAMES=2: phase is 1,
    // so the blank row 7 of the cursor glyph lights in its colour
    px(66, 15, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
